// File: rtl/systolic_skew_feeder.sv
// Edge feeder sitting directly upstream of an N x N PE array.
//
// Accepts one vector of N activations and N weights per valid/ready beat and re-times it
// into the diagonal wavefront the array expects: row lane i and column lane j are delayed
// by i and j extra cycles. Each lane carries its own fire bit. After the beat tagged with
// in_last, the feeder stops accepting input, lets the skew lines drain, and pulses done
// once the last operand has entered the array.
//
// Ports:
//   clk, rstn      clock; synchronous active-low reset
//   clear          synchronous abort, same effect as reset
//   in_valid/ready input handshake; in_last marks the final vector of a job
//   in_a, in_w     N packed signed bytes (lane i at [8i+7:8i])
//   row_a, row_f   skewed activations and fire, one lane per array row
//   col_w, col_f   skewed weights and fire, one lane per array column
//   busy           high from the first beat of a job through the final flush cycle
//   done           one-cycle pulse at end of job
//   beat_count     vectors accepted in the current or last job (saturating)
module systolic_skew_feeder #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_last,
  input  logic [N*8-1:0]  in_a,
  input  logic [N*8-1:0]  in_w,
  output logic [N*8-1:0]  row_a,
  output logic [N-1:0]    row_f,
  output logic [N*8-1:0]  col_w,
  output logic [N-1:0]    col_f,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   beat_count
);

  localparam int unsigned FW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StStream, StFlush, StDone} state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [CW-1:0] beat_count_q, beat_count_d;
  logic          beat;

  assign in_ready   = (state_q == StIdle) || (state_q == StStream);
  assign beat       = in_valid && in_ready;
  assign busy       = (state_q == StStream) || (state_q == StFlush);
  assign done       = (state_q == StDone);
  assign beat_count = beat_count_q;

  // The flush counter is loaded with N-1 and FLUSH is held through the cycle it reads zero,
  // so the deepest lane (N cycles of latency) has emitted its last slot before DONE.
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    beat_count_d = beat_count_q;
    case (state_q)
      StIdle: begin
        if (beat) begin
          beat_count_d = CW'(1);
          flush_cnt_d  = FW'(N - 1);
          state_d      = in_last ? StFlush : StStream;
        end
      end
      StStream: begin
        if (beat) begin
          if (beat_count_q != '1) begin
            beat_count_d = beat_count_q + CW'(1);
          end
          if (in_last) begin
            flush_cnt_d = FW'(N - 1);
            state_d     = StFlush;
          end
        end
      end
      StFlush: begin
        if (flush_cnt_q == '0) begin
          state_d = StDone;
        end else begin
          flush_cnt_d = flush_cnt_q - FW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      state_q      <= StIdle;
      flush_cnt_q  <= '0;
      beat_count_q <= '0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      beat_count_q <= beat_count_d;
    end
  end

  // Lane i is a shift register of depth i+1 holding {fire, data}. Every cycle shifts; a
  // cycle without a beat inserts a zero slot so lanes stay diagonally aligned. Row lane i
  // and column lane i have identical depth, so they share one fire line.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [i:0]      fire_q;
    logic [i:0][7:0] a_q;
    logic [i:0][7:0] w_q;

    always_ff @(posedge clk) begin
      if (!rstn || clear) begin
        fire_q <= '0;
        a_q    <= '0;
        w_q    <= '0;
      end else begin
        fire_q[0] <= beat;
        a_q[0]    <= beat ? in_a[8*i +: 8] : 8'h00;
        w_q[0]    <= beat ? in_w[8*i +: 8] : 8'h00;
        for (int k = 1; k <= i; k++) begin
          fire_q[k] <= fire_q[k-1];
          a_q[k]    <= a_q[k-1];
          w_q[k]    <= w_q[k-1];
        end
      end
    end

    assign row_f[i]         = fire_q[i];
    assign col_f[i]         = fire_q[i];
    assign row_a[8*i +: 8]  = a_q[i];
    assign col_w[8*i +: 8]  = w_q[i];
  end

endmodule
